// File: rtl/gpio_pkg.sv
// Register map and bus helpers for the GPIOA Wishbone slave.
// Offsets are word indices (adr[5:2]) and are shared with firmware headers.
package gpio_pkg;

    typedef logic [3:0] gpio_reg_idx_t;

    localparam gpio_reg_idx_t GPIO_DATA_OUT = 4'd0;
    localparam gpio_reg_idx_t GPIO_DATA_IN  = 4'd1;
    localparam gpio_reg_idx_t GPIO_DIR      = 4'd2;
    localparam gpio_reg_idx_t GPIO_OUT_SET  = 4'd3;
    localparam gpio_reg_idx_t GPIO_OUT_CLR  = 4'd4;
    localparam gpio_reg_idx_t GPIO_OUT_TGL  = 4'd5;
    localparam gpio_reg_idx_t GPIO_IRQ_EN   = 4'd6;
    localparam gpio_reg_idx_t GPIO_IRQ_RISE = 4'd7;
    localparam gpio_reg_idx_t GPIO_IRQ_FALL = 4'd8;
    localparam gpio_reg_idx_t GPIO_IRQ_STAT = 4'd9;

    // Expand Wishbone byte selects into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        byte_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Pin input synchroniser with a one-cycle history flop and rise/fall detection.
// Edges stay masked until the chain and history flop hold real post-reset samples.
module gpio_in_sync #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [ARM_W-1:0] arm_cnt_q;
    logic             armed;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q    <= '0;
            arm_cnt_q <= ARM_W'(ARM_CYCLES);
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (arm_cnt_q != '0) begin
                arm_cnt_q <= arm_cnt_q - ARM_W'(1);
            end
        end
    end

    always_comb begin
        armed  = (arm_cnt_q == '0);
        sync_o = sync_q[SYNC_STAGES-1];
        rise_o = armed ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;
        fall_o = armed ? (~sync_q[SYNC_STAGES-1] & prev_q) : '0;
    end

endmodule

// File: rtl/wb_gpio.sv
// Pipelined Wishbone GPIO slave: output/direction registers, synchronised inputs,
// sticky per-pin edge status and a registered level interrupt.
module wb_gpio
    import gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_we_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_stall_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe_o,
    output logic             irq_o
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] en_q, en_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] stat_q, stat_d;
    logic             ack_q;
    logic [31:0]      dat_q;
    logic             irq_q;

    logic [WIDTH-1:0] sync_in, rise, fall;
    logic             req, wr_en;
    gpio_reg_idx_t    idx;
    logic [31:0]      sel_mask;
    logic [WIDTH-1:0] wmask, wbits, stat_clr;
    logic [31:0]      rd_data;
    logic             unused_adr;

    gpio_in_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .gpio_i (gpio_i),
        .sync_o (sync_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign req        = wb_cyc_i & wb_stb_i;
    assign wr_en      = req & wb_we_i;
    assign idx        = wb_adr_i[5:2];
    assign sel_mask   = byte_mask(wb_sel_i);
    assign wmask      = sel_mask[WIDTH-1:0];
    assign wbits      = wb_dat_i[WIDTH-1:0] & wmask;
    assign unused_adr = ^{wb_adr_i[31:6], wb_adr_i[1:0]};

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        en_d      = en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_clr  = '0;
        if (wr_en) begin
            case (idx)
                GPIO_DATA_OUT: out_d     = (out_q & ~wmask) | wbits;
                GPIO_DIR:      dir_d     = (dir_q & ~wmask) | wbits;
                GPIO_OUT_SET:  out_d     = out_q | wbits;
                GPIO_OUT_CLR:  out_d     = out_q & ~wbits;
                GPIO_OUT_TGL:  out_d     = out_q ^ wbits;
                GPIO_IRQ_EN:   en_d      = (en_q & ~wmask) | wbits;
                GPIO_IRQ_RISE: rise_en_d = (rise_en_q & ~wmask) | wbits;
                GPIO_IRQ_FALL: fall_en_d = (fall_en_q & ~wmask) | wbits;
                GPIO_IRQ_STAT: stat_clr  = wbits;
                default:       ;
            endcase
        end
        // A newly detected edge overrides a same-cycle W1C.
        stat_d = (stat_q & ~stat_clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            GPIO_DATA_OUT: rd_data[WIDTH-1:0] = out_q;
            GPIO_DATA_IN:  rd_data[WIDTH-1:0] = sync_in;
            GPIO_DIR:      rd_data[WIDTH-1:0] = dir_q;
            GPIO_IRQ_EN:   rd_data[WIDTH-1:0] = en_q;
            GPIO_IRQ_RISE: rd_data[WIDTH-1:0] = rise_en_q;
            GPIO_IRQ_FALL: rd_data[WIDTH-1:0] = fall_en_q;
            GPIO_IRQ_STAT: rd_data[WIDTH-1:0] = stat_q;
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= OUT_RESET;
            dir_q     <= '0;
            en_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            en_q      <= en_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            ack_q     <= req;
            dat_q     <= (req & ~wb_we_i) ? rd_data : '0;
            irq_q     <= |(stat_q & en_q);
        end
    end

    // Gate with cyc so an abandoned cycle never sees a stale acknowledge.
    assign wb_ack_o   = ack_q & wb_cyc_i;
    assign wb_dat_o   = dat_q;
    assign wb_err_o   = 1'b0;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = out_q;
    assign gpio_oe_o  = dir_q;
    assign irq_o      = irq_q;

endmodule
